// File: rtl/exec_unit_seq.sv
// exec_unit_seq: execute-stage consumer of the decoder's 4-bit alu_cont code.
//   Integer ops (add, sub, and, or, slt) complete one cycle after accept.
//   FP ops are launched on an external FP datapath. A down-counter loaded with
//   LAT-1 tracks the op, and fpu_result is captured on the cycle the count reaches 0.
//   Results sit in a one-deep output register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       op handshake from decode (alu_cont, src_a, src_b, rd_in)
//   out_valid/out_ready     result handshake toward writeback (result, rd_out, zero, illegal)
//   stall                   in_valid & ~in_ready
//   fpu_start/fpu_op/fpu_a/fpu_b   launch pulse and held operands for the FP datapath
//   fpu_result              FP datapath result, sampled when the counter expires
//
// Optional build macro EXEC_PERF_CNT_EN adds perf_stall_cycles[31:0]. This is a
// saturating count of the cycles in which stall=1.
//
// state   | meaning
// IDLE    | may accept a new op
// FP_WAIT | FP op in flight, counter running, no accepts
module exec_unit_seq #(
   parameter int XLEN      = 32,
   parameter int LAT_FADD  = 2,
   parameter int LAT_FMUL  = 2,
   parameter int LAT_FDIV  = 10,
   parameter int LAT_FSQRT = 12,
   parameter int CNT_W     = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_cont,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [4:0]      rd_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            zero,
   output logic            illegal,
   output logic            stall,
   output logic            fpu_start,
   output logic [2:0]      fpu_op,
   output logic [XLEN-1:0] fpu_a,
   output logic [XLEN-1:0] fpu_b,
   input  logic [XLEN-1:0] fpu_result
`ifdef EXEC_PERF_CNT_EN
   ,
   output logic [31:0]     perf_stall_cycles
`endif
);

   typedef enum logic {
      IDLE    = 1'b0,
      FP_WAIT = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [4:0]        rd_pend;

   logic              is_fp;
   logic              op_illegal;
   logic [XLEN-1:0]   int_res;
   logic [2:0]        fp_op_dec;
   logic [CNT_W-1:0]  fp_lat;

   logic              accept;
   logic              load_int;
   logic              fp_done;

   // The output register is always free during FP_WAIT, so accepting only in
   // IDLE with a free/draining register is enough to keep FP completion from
   // overwriting an unconsumed result.
   assign in_ready = (state == IDLE) & (~out_valid | out_ready);
   assign stall    = in_valid & ~in_ready;
   assign accept   = in_valid & in_ready;
   assign load_int = accept & ~is_fp;
   assign fp_done  = (state == FP_WAIT) & (cnt == '0);

   always_comb begin
      is_fp      = 1'b0;
      op_illegal = 1'b0;
      int_res    = '0;
      fp_op_dec  = 3'd0;
      fp_lat     = '0;
      case (alu_cont)
         4'b0000: int_res = src_a + src_b;
         4'b0001: int_res = src_a - src_b;
         4'b0010: int_res = src_a & src_b;
         4'b0011: int_res = src_a | src_b;
         4'b0101: int_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         4'b1000: begin is_fp = 1'b1; fp_op_dec = 3'd0; fp_lat = CNT_W'(LAT_FADD - 1);  end
         4'b1001: begin is_fp = 1'b1; fp_op_dec = 3'd1; fp_lat = CNT_W'(LAT_FADD - 1);  end
         4'b1010: begin is_fp = 1'b1; fp_op_dec = 3'd2; fp_lat = CNT_W'(LAT_FMUL - 1);  end
         4'b1011: begin is_fp = 1'b1; fp_op_dec = 3'd3; fp_lat = CNT_W'(LAT_FDIV - 1);  end
         4'b1100: begin is_fp = 1'b1; fp_op_dec = 3'd4; fp_lat = CNT_W'(LAT_FSQRT - 1); end
         default: op_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_fp) state_nxt = FP_WAIT;
         FP_WAIT: if (cnt == '0)       state_nxt = IDLE;
         default:                      state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_pend   <= '0;
         fpu_start <= 1'b0;
         fpu_op    <= 3'd0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         rd_out    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         state     <= state_nxt;
         fpu_start <= accept & is_fp;

         if (accept && is_fp) begin
            fpu_op  <= fp_op_dec;
            fpu_a   <= src_a;
            fpu_b   <= src_b;
            rd_pend <= rd_in;
            cnt     <= fp_lat;
         end else if (state == FP_WAIT && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end

         if (load_int) begin
            result    <= int_res;
            rd_out    <= rd_in;
            zero      <= (int_res == '0);
            illegal   <= op_illegal;
            out_valid <= 1'b1;
         end else if (fp_done) begin
            result    <= fpu_result;
            rd_out    <= rd_pend;
            zero      <= (fpu_result == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef EXEC_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= '0;
      end else if (stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
         perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exec_unit_seq.sv
module tb_exec_unit_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_cont;
   logic [31:0] src_a, src_b;
   logic [4:0]  rd_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [4:0]  rd_out;
   logic        zero, illegal, stall, fpu_start;
   logic [2:0]  fpu_op;
   logic [31:0] fpu_a, fpu_b, fpu_result;
`ifdef EXEC_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
`endif

   exec_unit_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_cont(alu_cont), .src_a(src_a), .src_b(src_b), .rd_in(rd_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .rd_out(rd_out), .zero(zero), .illegal(illegal),
      .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result)
`ifdef EXEC_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      logic        z;
      logic        ill;
   } exp_t;

   exp_t sb_q[$];

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] fr, input logic [4:0] rd);
      exp_t e;
      e.rd  = rd;
      e.ill = 1'b0;
      case (c)
         4'd0:  e.res = a + b;
         4'd1:  e.res = a - b;
         4'd2:  e.res = a & b;
         4'd3:  e.res = a | b;
         4'd5:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8, 4'd9, 4'd10, 4'd11, 4'd12: e.res = fr;
         default: begin e.res = 32'd0; e.ill = 1'b1; end
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   // Scoreboard: expectations pushed on accept, popped when a result drains.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               n_chk++;
               $display("FAIL sb_unexpected: got result 0x%08h expected no output", result);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sb_result", result, e.res);
               chk("sb_rd", 32'(rd_out), 32'(e.rd));
               chk("sb_zero", 32'(zero), 32'(e.z));
               chk("sb_illegal", 32'(illegal), 32'(e.ill));
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(alu_cont, src_a, src_b, fpu_result, rd_in));
      end
   end

   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      int k;
      k = 0;
      in_valid = 1'b1; alu_cont = c; src_a = a; src_b = b; rd_in = rd;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("issue_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  c;
      logic [31:0] a, b;
      logic [31:0] res;
      logic        z, ill;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int cyc, n_st, n_fs, n_ov;

      vecs[0] = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1] = '{4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[2] = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0};
      vecs[3] = '{4'b0011, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0, 1'b0, 1'b0};
      vecs[4] = '{4'b0101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
      vecs[5] = '{4'b0101, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6] = '{4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[7] = '{4'b0000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0};
      vecs[8] = '{4'b0100, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b1};
      vecs[9] = '{4'b0001, 32'h0000_0010, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; alu_cont = 4'd0; src_a = '0; src_b = '0;
      rd_in = '0; out_ready = 1'b1; fpu_result = '0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd_out", 32'(rd_out), 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_fpu_start", 32'(fpu_start), 32'd0);
      chk("rst_fpu_op", 32'(fpu_op), 32'd0);
      chk("rst_fpu_ab", fpu_a | fpu_b, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Integer table, back-to-back with out_ready=1.
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].c, vecs[i].a, vecs[i].b, 5'(i + 1));
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_result", i), result, vecs[i].res);
         chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
         chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vecs[i].ill));
      end

      // fdiv latency and stall, with the next op held behind it.
      fpu_result = 32'h4049_0FDB;
      in_valid = 1'b1; alu_cont = 4'b1011; src_a = 32'h4000_0000; src_b = 32'h3F80_0000; rd_in = 5'd7;
      @(negedge clk);
      chk("fdiv_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      alu_cont = 4'b0000; src_a = 32'd2; src_b = 32'd3; rd_in = 5'd8;
      cyc = 1; n_st = 0; n_fs = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) break;
         if (stall) n_st++;
         if (fpu_start) n_fs++;
         if (cyc == 1) chk("fdiv_start_c1", 32'(fpu_start), 32'd1);
         if (cyc == 10) begin
            chk("fdiv_op_held", 32'(fpu_op), 32'd3);
            chk("fdiv_a_held", fpu_a, 32'h4000_0000);
            chk("fdiv_b_held", fpu_b, 32'h3F80_0000);
         end
         cyc++;
      end
      chk("fdiv_latency", 32'(cyc), 32'd11);
      chk("fdiv_stall_cycles", 32'(n_st), 32'd10);
      chk("fdiv_start_pulses", 32'(n_fs), 32'd1);
      chk("fdiv_result", result, 32'h4049_0FDB);
      chk("fdiv_rd", 32'(rd_out), 32'd7);
      chk("fdiv_next_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_fdiv_add", result, 32'd5);
      chk("post_fdiv_rd", 32'(rd_out), 32'd8);

      // fsqrt: fpu_b still carries src_b; latency 12 + 1.
      fpu_result = 32'h0000_0000;
      issue(4'b1100, 32'h4080_0000, 32'hDEAD_BEEF, 5'd9);
      chk("fsqrt_op", 32'(fpu_op), 32'd4);
      chk("fsqrt_b", fpu_b, 32'hDEAD_BEEF);
      cyc = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) break;
         cyc++;
      end
      chk("fsqrt_latency", 32'(cyc), 32'd13);
      chk("fsqrt_zero", 32'(zero), 32'd1);
      @(posedge clk); #1;

      // Backpressure: hold 5 cycles, then drain and accept on the same edge.
      issue(4'b0000, 32'd10, 32'd20, 5'd3);
      out_ready = 1'b0;
      in_valid = 1'b1; alu_cont = 4'b0011; src_a = 32'h0000_000F; src_b = 32'h0000_00F0; rd_in = 5'd4;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_stall", 32'(stall), 32'd1);
         chk("bp_result_held", result, 32'd30);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_new_valid", 32'(out_valid), 32'd1);
      chk("bp_new_result", result, 32'h0000_00FF);
      chk("bp_new_rd", 32'(rd_out), 32'd4);
      @(posedge clk); #1;
      chk("bp_drained", 32'(out_valid), 32'd0);

      // Reset in cycle 3 of an fsqrt.
      fpu_result = 32'h1111_2222;
      issue(4'b1100, 32'h4100_0000, 32'd0, 5'd12);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      sb_q.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_fpu_op", 32'(fpu_op), 32'd0);
      chk("mid_rst_fpu_a", fpu_a, 32'd0);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_ov = 0; n_fs = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) n_ov++;
         if (fpu_start) n_fs++;
      end
      chk("post_rst_no_valid", 32'(n_ov), 32'd0);
      chk("post_rst_no_start", 32'(n_fs), 32'd0);

      // Machine recovers after abort.
      issue(4'b0001, 32'd100, 32'd1, 5'd2);
      chk("recover_result", result, 32'd99);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
